// File: rtl/seq_gen_arbiter_pkg.sv
// Shared types and helpers for the sequence-generator arbiter: FSM state,
// default widths and the round-robin winner search.
package seq_gen_pkg;

    localparam int SEQ_DATA_W = 8;
    localparam int SEQ_LEN_W  = 4;
    localparam int RR_MAX     = 8;
    localparam int RR_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // First set bit of req searching upward from ptr+1 with wrap at n.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] ptr,
        input int                  n
    );
        logic [RR_IDX_W-1:0] win;
        logic [RR_IDX_W-1:0] idx;
        logic                hit;
        win = '0;
        hit = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            idx = RR_IDX_W'((int'(ptr) + i) % n);
            if (!hit && req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/seq_gen_arbiter_if.sv
// Requester, generator and output-port signals of the arbiter.
// slave = arbiter side, master = clients/generator/consumer side.
interface seq_gen_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int DATA_W  = 8
) ();
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     gen_enable;
    logic [DATA_W-1:0]        gen_data;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  req, req_len, gen_data, out_ready,
        output gnt, done, busy, gen_enable, out_data, out_valid
    );

    modport master (
        output req, req_len, gen_data, out_ready,
        input  gnt, done, busy, gen_enable, out_data, out_valid
    );
endinterface

// File: rtl/seq_gen_arbiter_buf2.sv
// Two-entry FIFO between generator data and the output port.
// Writer never pushes into a full buffer without a simultaneous pop.
module seq_gen_buf2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [1:0]        o_occ
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              w_pop;

    assign w_pop     = i_rd_en && (r_occ != 2'd0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_occ     = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_wr_en, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: rtl/seq_gen_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one sequence generator
// between NUM_REQ requesters; returned bytes leave through a 2-entry buffer.
module seq_gen_arbiter
    import seq_gen_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = SEQ_LEN_W,
    parameter int DATA_W  = SEQ_DATA_W
) (
    input logic              clk,
    input logic              reset_n,
    seq_gen_arbiter_if.slave bus
);
    localparam int CNT_W = LEN_W + 1;

    seq_state_t          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_busy;
    logic [CNT_W-1:0]    r_issue_cnt;
    logic [CNT_W-1:0]    r_ret_cnt;
    logic [RR_IDX_W-1:0] r_rr_ptr;
    logic                r_inflight;

    logic [RR_MAX-1:0]   w_req_ext;
    logic [RR_IDX_W-1:0] w_winner;
    logic [LEN_W-1:0]    w_win_len;
    logic [CNT_W-1:0]    w_burst_len;
    logic [1:0]          w_occ;
    logic [DATA_W-1:0]   w_head;
    logic                w_out_valid;
    logic                w_pop;
    logic [2:0]          w_level;
    logic                w_gen_enable;
    logic                w_last_pop;

    assign w_req_ext   = RR_MAX'(bus.req);
    assign w_winner    = rr_pick(w_req_ext, r_rr_ptr, NUM_REQ);
    assign w_win_len   = bus.req_len[int'(w_winner)*LEN_W +: LEN_W];
    assign w_burst_len = (w_win_len == '0) ? CNT_W'(2**LEN_W) : CNT_W'(w_win_len);

    assign w_out_valid = (w_occ != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    // Credit: buffered + in-flight bytes after this cycle's pop must leave room.
    assign w_level      = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_gen_enable = (r_state == RUN) && (r_issue_cnt != '0) && (w_level < 3'd2);
    assign w_last_pop   = (r_state == DRAIN) && w_pop && (r_ret_cnt == CNT_W'(1));

    seq_gen_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_wr_en   (r_inflight),
        .i_wr_data (bus.gen_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_occ     (w_occ)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_rr_ptr    <= RR_IDX_W'(NUM_REQ - 1);
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_gen_enable;
            if (w_pop) begin
                r_ret_cnt <= r_ret_cnt - CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (bus.req != '0) begin
                        r_gnt       <= NUM_REQ'(1) << w_winner;
                        r_issue_cnt <= w_burst_len;
                        r_ret_cnt   <= w_burst_len;
                        r_rr_ptr    <= w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_gen_enable) begin
                        r_issue_cnt <= r_issue_cnt - CNT_W'(1);
                        if (r_issue_cnt == CNT_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_pop) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.busy       = r_busy;
    assign bus.done       = w_last_pop ? r_gnt : '0;
    assign bus.gen_enable = w_gen_enable;
    assign bus.out_data   = w_head;
    assign bus.out_valid  = w_out_valid;
endmodule

// File: tb/tb_seq_gen_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked by a
// burst-level reference model sampled on the falling clock edge.
module tb_seq_gen_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 8;

    logic clk;
    logic reset_n;

    seq_gen_arbiter_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    seq_gen_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Generator model: counter from AF, data valid the cycle after enable.
    logic [DATA_W-1:0] gen_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_cnt      <= 8'hAF;
            bus.gen_data <= '0;
        end else if (bus.gen_enable) begin
            bus.gen_data <= gen_cnt;
            gen_cnt      <= gen_cnt + 8'd1;
        end
    end

    // Reference model state
    logic [NUM_REQ-1:0]       snap_req;
    logic [NUM_REQ*LEN_W-1:0] snap_len;
    logic [DATA_W-1:0]        m_exp_byte;
    int  m_ptr, m_win, m_len, m_got, m_en, m_cycles, m_out;
    bit  m_active, m_gap, m_allready;
    int  last_bytes, n_done;
    int  grant_log[$];

    function automatic int rr_model(input logic [NUM_REQ-1:0] r, input int ptr);
        int order[$];
        for (int k = 1; k <= NUM_REQ; k++) order.push_back((ptr + k) % NUM_REQ);
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] exp_done;
        logic [LEN_W-1:0]   l;
        bit pop;
        if (!reset_n) begin
            chk("rst_outputs", {bus.gnt, bus.done, bus.busy, bus.gen_enable, bus.out_valid, bus.out_data}, 0);
            m_active = 0; m_gap = 0; m_ptr = NUM_REQ - 1; m_out = 0;
            m_exp_byte = 8'hAF; snap_req = '0; snap_len = '0;
        end else begin
            pop = bus.out_valid && bus.out_ready;
            if (!m_active) begin
                if (m_gap) m_gap = 0;
                else if (snap_req != '0) begin
                    m_win = rr_model(snap_req, m_ptr);
                    m_ptr = m_win;
                    l = snap_len[m_win*LEN_W +: LEN_W];
                    m_len = (l == 0) ? (1 << LEN_W) : int'(l);
                    m_active = 1; m_got = 0; m_en = 0; m_cycles = 0; m_allready = 1;
                    grant_log.push_back(m_win);
                    chk("first_enable", bus.gen_enable, 1'b1);
                end
            end
            exp_gnt  = m_active ? (NUM_REQ'(1) << m_win) : '0;
            exp_done = '0;
            chk("gnt", bus.gnt, exp_gnt);
            chk("busy", bus.busy, m_active);
            if (m_active) begin
                m_cycles++;
                if (!bus.out_ready) m_allready = 0;
                if (bus.gen_enable) m_en++;
                chk("issue_count", (m_en <= m_len), 1'b1);
                if (pop) begin
                    chk("data", bus.out_data, m_exp_byte);
                    m_exp_byte = m_exp_byte + 8'd1;
                    m_got++;
                    if (m_got == m_len) exp_done = exp_gnt;
                end
            end else begin
                chk("idle_quiet", {bus.gen_enable, bus.out_valid}, 2'b00);
            end
            chk("done", bus.done, exp_done);
            m_out = m_out + int'(bus.gen_enable) - int'(pop);
            chk("credit", (m_out <= 2), 1'b1);
            if (exp_done != '0) begin
                if (m_allready) chk("burst_latency", m_cycles, m_len + 2);
                last_bytes = m_got;
                n_done++;
                m_active = 0;
                m_gap = 1;
            end
            snap_req = bus.req;
            snap_len = bus.req_len;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!bus.busy && n < budget) begin cyc(1); n++; end
        chk("wait_busy", bus.busy, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin cyc(1); n++; end
        chk("wait_valid", bus.out_valid, 1'b1);
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((bus.busy || bus.out_valid) && n < budget) begin cyc(1); n++; end
        chk("wait_idle", bus.busy, 1'b0);
        cyc(1);
    endtask

    int base, dones_before;

    initial begin
        reset_n = 1'b0;
        bus.req = '0;
        bus.req_len = '0;
        bus.out_ready = 1'b1;
        n_done = 0; last_bytes = 0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);

        // Round robin from reset: 0101 alternates starting at requester 0
        base = grant_log.size();
        bus.req = 4'b0101;
        bus.req_len = {4'd2, 4'd2, 4'd2, 4'd2};
        for (int n = 0; n < 200 && grant_log.size() < base + 3; n++) cyc(1);
        bus.req = '0;
        wait_quiet(100);
        chk("rr_count", (grant_log.size() >= base + 3), 1'b1);
        if (grant_log.size() >= base + 3) begin
            chk("rr_grant0", grant_log[base], 0);
            chk("rr_grant1", grant_log[base+1], 2);
            chk("rr_grant2", grant_log[base+2], 0);
        end

        // Single burst, no backpressure
        bus.req = 4'b0001;
        bus.req_len = {4'd9, 4'd9, 4'd9, 4'd3};
        wait_busy(10);
        bus.req = '0;
        wait_quiet(50);
        chk("single_bytes", last_bytes, 3);

        // Backpressure: consumer stalls from the first valid byte for 5 cycles
        bus.out_ready = 1'b0;
        bus.req = 4'b0001;
        bus.req_len = {4'd1, 4'd1, 4'd1, 4'd4};
        wait_busy(10);
        bus.req = '0;
        wait_valid(10);
        cyc(5);
        chk("bp_issued", m_en, 2);
        bus.out_ready = 1'b1;
        wait_quiet(50);
        chk("bp_bytes", last_bytes, 4);

        // Length 0 encodes 16 bytes
        bus.req = 4'b0010;
        bus.req_len = {4'd3, 4'd3, 4'd0, 4'd3};
        wait_busy(10);
        bus.req = '0;
        wait_quiet(100);
        chk("len0_bytes", last_bytes, 16);

        // Request dropped right after grant, length changed mid-burst
        bus.req = 4'b1000;
        bus.req_len = {4'd5, 4'd1, 4'd1, 4'd1};
        wait_busy(10);
        bus.req = '0;
        bus.req_len = {4'd1, 4'd1, 4'd1, 4'd1};
        wait_quiet(50);
        chk("drop_bytes", last_bytes, 5);

        // Reset during byte 2 of 4
        dones_before = n_done;
        bus.req = 4'b0001;
        bus.req_len = {4'd2, 4'd2, 4'd2, 4'd4};
        wait_busy(10);
        bus.req = '0;
        cyc(3);
        #2 reset_n = 1'b0;
        #1 chk("rst_async", {bus.gnt, bus.done, bus.busy, bus.gen_enable, bus.out_valid, bus.out_data}, 0);
        cyc(2);
        bus.req = 4'b0001;
        reset_n = 1'b1;
        wait_busy(10);
        chk("post_rst_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        wait_quiet(50);
        chk("rst_no_done", n_done, dones_before + 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int hold;
            bus.req = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            bus.req_len = (NUM_REQ*LEN_W)'($urandom);
            hold = $urandom_range(1, 30);
            for (int c = 0; c < hold; c++) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) bus.req_len = (NUM_REQ*LEN_W)'($urandom);
                cyc(1);
            end
        end
        bus.req = '0;
        bus.out_ready = 1'b1;
        wait_quiet(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
